// File: rtl/tile_stream_extractor.sv
// Register-based tile extractor: buffers the last T raster rows of a channel-interleaved
// pixel stream and emits every overlapping T x T x C tile over a valid/ready handshake.
module tile_stream_extractor #(
  parameter int KERNEL_SIZE        = 3,
  parameter int INPUT_TILE_SIZE    = 4,
  parameter int INPUT_IMAGE_WIDTH  = 10,
  parameter int INPUT_IMAGE_HEIGHT = 6,
  parameter int INPUT_DATA_WIDTH   = 8,
  parameter int CHANNELS           = 3,
  localparam int T   = INPUT_TILE_SIZE,
  localparam int S   = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
  localparam int NTR = (INPUT_IMAGE_HEIGHT - INPUT_TILE_SIZE) / S + 1,
  localparam int NTC = (INPUT_IMAGE_WIDTH - INPUT_TILE_SIZE) / S + 1,
  localparam int TRW = (NTR > 1) ? $clog2(NTR) : 1,
  localparam int TCW = (NTC > 1) ? $clog2(NTC) : 1,
  localparam int TDW = T * T * CHANNELS * INPUT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] i_pixel_data,
  input  logic                        i_pixel_data_valid,
  output logic                        o_pixel_ready,
  output logic [TDW-1:0]              o_tile_data,
  output logic                        o_tile_valid,
  input  logic                        i_tile_ready,
  output logic [TRW-1:0]              o_tile_row,
  output logic [TCW-1:0]              o_tile_col,
  output logic                        o_frame_done
);

  localparam int W   = INPUT_IMAGE_WIDTH;
  localparam int H   = INPUT_IMAGE_HEIGHT;
  localparam int C   = CHANNELS;
  localparam int DW  = INPUT_DATA_WIDTH;
  localparam int CHW = (C > 1) ? $clog2(C) : 1;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam int RW  = (H > 1) ? $clog2(H) : 1;
  localparam int RBW = (T > 1) ? $clog2(T) : 1;
  localparam int MW  = (W * C > 1) ? $clog2(W * C) : 1;
  localparam int NRW = $clog2(NTR + 1);
  localparam int NCW = $clog2(NTC + 1);

  logic [DW-1:0]  mem [T][W*C];
  logic [CHW-1:0] ch;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [RBW-1:0] rb;
  logic [NRW-1:0] next_tr;
  logic [NCW-1:0] next_tc;
  logic           accept, last_ch, last_col, last_row, row_hit, col_hit, complete;
  logic [MW-1:0]  widx;
  logic [RBW-1:0] bsel;
  logic [MW-1:0]  csel;
  int             c0;
  logic [TDW-1:0] snap;

  assign o_pixel_ready = !(o_tile_valid && !i_tile_ready);
  assign accept        = i_pixel_data_valid && o_pixel_ready;
  assign last_ch       = (int'(ch) == C - 1);
  assign last_col      = (int'(col) == W - 1);
  assign last_row      = (int'(row) == H - 1);
  // next_tr/next_tc name the next tile row/column whose bottom-right corner is still ahead
  assign row_hit  = (int'(next_tr) < NTR) && (int'(row) == int'(next_tr) * S + T - 1);
  assign col_hit  = (int'(next_tc) < NTC) && (int'(col) == int'(next_tc) * S + T - 1);
  assign complete = accept && last_ch && row_hit && col_hit;
  assign widx     = MW'(int'(col) * C + int'(ch));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch      <= '0;
      col     <= '0;
      row     <= '0;
      rb      <= '0;
      next_tr <= '0;
      next_tc <= '0;
    end else if (accept) begin
      if (last_ch) begin
        ch <= '0;
        if (col_hit) next_tc <= next_tc + NCW'(1);
        if (last_col) begin
          col     <= '0;
          next_tc <= '0;
          if (row_hit) next_tr <= next_tr + NRW'(1);
          if (last_row) begin
            row     <= '0;
            rb      <= '0;
            next_tr <= '0;
          end else begin
            row <= row + RW'(1);
            rb  <= (int'(rb) == T - 1) ? '0 : rb + RBW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        ch <= ch + CHW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[rb][widx] <= i_pixel_data;
  end

  // Gather the tile ending at the current beat; buffer rb holds the tile's bottom row.
  always_comb begin
    snap = '0;
    bsel = '0;
    csel = '0;
    c0   = (int'(col) >= T - 1) ? int'(col) - (T - 1) : 0;
    for (int k = 0; k < C; k++) begin
      for (int r = 0; r < T; r++) begin
        for (int cc = 0; cc < T; cc++) begin
          bsel = RBW'((int'(rb) + r + 1) % T);
          csel = MW'((c0 + cc) * C + k);
          if (k == C - 1 && r == T - 1 && cc == T - 1)
            snap[((k * T + r) * T + cc) * DW +: DW] = i_pixel_data;
          else
            snap[((k * T + r) * T + cc) * DW +: DW] = mem[bsel][csel];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tile_data  <= '0;
      o_tile_valid <= 1'b0;
      o_tile_row   <= '0;
      o_tile_col   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= accept && last_ch && last_col && last_row;
      if (complete) begin
        o_tile_data  <= snap;
        o_tile_valid <= 1'b1;
        o_tile_row   <= TRW'(next_tr);
        o_tile_col   <= TCW'(next_tc);
      end else if (o_tile_valid && i_tile_ready) begin
        o_tile_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_stream_extractor.sv
// Scoreboard bench for tile_stream_extractor: expected tiles are cut straight out of a
// frame array and queued at stimulus time; a negedge monitor pops them on each handshake.
module tb_tile_stream_extractor;
  localparam int T = 4, K = 3, W = 10, H = 6, C = 3, DW = 8;
  localparam int S = T - K + 1, NTR = (H - T) / S + 1, NTC = (W - T) / S + 1;
  localparam int NB = W * H * C, TDW = T * T * C * DW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [DW-1:0]  i_pixel_data = '0;
  logic           i_pixel_data_valid = 1'b0;
  logic           o_pixel_ready;
  logic [TDW-1:0] o_tile_data;
  logic           o_tile_valid;
  logic           i_tile_ready;
  logic [0:0]     o_tile_row;
  logic [1:0]     o_tile_col;
  logic           o_frame_done;

  tile_stream_extractor #(
    .KERNEL_SIZE(K), .INPUT_TILE_SIZE(T), .INPUT_IMAGE_WIDTH(W),
    .INPUT_IMAGE_HEIGHT(H), .INPUT_DATA_WIDTH(DW), .CHANNELS(C)
  ) dut (
    .clk(clk), .reset(reset),
    .i_pixel_data(i_pixel_data), .i_pixel_data_valid(i_pixel_data_valid),
    .o_pixel_ready(o_pixel_ready), .o_tile_data(o_tile_data),
    .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
    .o_tile_row(o_tile_row), .o_tile_col(o_tile_col), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TDW-1:0] data;
    int             row;
    int             col;
  } tile_t;

  tile_t         exp_q[$];
  logic [DW-1:0] pix [NB];
  int            checks = 0, errors = 0, fdone_cnt = 0;
  int            ready_mode = 1;
  int            test_id = 0;

  task automatic chk(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(input int k, input int r, input int cc);
    return o_tile_data[((k * T + r) * T + cc) * DW +: DW];
  endfunction

  // Reference: tile (i,j) is the TxT window at (i*S, j*S); it is emitted only if its
  // bottom-right sample (last channel) is reached before abort_at.
  task automatic push_frame(input int abort_at);
    tile_t t;
    int    cb;
    for (int i = 0; i < NTR; i++)
      for (int j = 0; j < NTC; j++) begin
        cb = ((i * S + T - 1) * W + j * S + T - 1) * C + C - 1;
        if (cb < abort_at) begin
          t.data = '0;
          t.row  = i;
          t.col  = j;
          for (int k = 0; k < C; k++)
            for (int r = 0; r < T; r++)
              for (int cc = 0; cc < T; cc++)
                t.data[((k * T + r) * T + cc) * DW +: DW] = pix[((i * S + r) * W + j * S + cc) * C + k];
          exp_q.push_back(t);
        end
      end
  endtask

  task automatic send_beat(input int b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        i_pixel_data_valid = 1'b0;
        i_pixel_data = DW'($urandom);
        @(posedge clk);
        #1;
      end
    end
    i_pixel_data = pix[b];
    i_pixel_data_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_pixel_ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: beat %0d got no ready expected ready within 2000 cycles", b);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hooks(input int b);
    logic [TDW-1:0] held;
    if (test_id == 1) begin
      case (b)
        100: chk("t1_no_tile_before_101", o_tile_valid, 1'b0);
        101: begin
          chk("t1_tile00_valid", o_tile_valid, 1'b1);
          chk("t1_tile00_row", o_tile_row, 1'b0);
          chk("t1_tile00_col", o_tile_col, 2'd0);
          chk("t1_tile00_e000", el(0, 0, 0), 8'd0);
          chk("t1_tile00_e112", el(1, 1, 2), 8'd37);
          chk("t1_tile00_e233", el(2, 3, 3), 8'd101);
        end
        107: begin
          chk("t1_tile01_valid", o_tile_valid, 1'b1);
          chk("t1_tile01_col", o_tile_col, 2'd1);
        end
        161: begin
          chk("t1_tile10_valid", o_tile_valid, 1'b1);
          chk("t1_tile10_row", o_tile_row, 1'b1);
          chk("t1_tile10_col", o_tile_col, 2'd0);
        end
        167: chk("t1_tile11_e000", el(0, 0, 0), 8'd66);
        178: chk("t1_no_done_early", o_frame_done, 1'b0);
        179: begin
          chk("t1_tile13_valid", o_tile_valid, 1'b1);
          chk("t1_tile13_row", o_tile_row, 1'b1);
          chk("t1_tile13_col", o_tile_col, 2'd3);
          chk("t1_frame_done", o_frame_done, 1'b1);
        end
        default: ;
      endcase
    end else if (test_id == 3 && b == 101) begin
      chk("t3_stall_ready", o_pixel_ready, 1'b0);
      held = o_tile_data;
      repeat (20) begin
        @(negedge clk);
        chk("t3_stall_ready_hold", o_pixel_ready, 1'b0);
        chk("t3_stall_data_hold", o_tile_data, held);
      end
      ready_mode = 1;
    end
  endtask

  task automatic run_frame(input bit rnd, input int abort_at, input bit gaps);
    for (int b = 0; b < NB; b++) pix[b] = rnd ? DW'($urandom) : DW'(b);
    push_frame(abort_at);
    for (int b = 0; b < NB && b < abort_at; b++) begin
      send_beat(b, gaps);
      hooks(b);
    end
  endtask

  task automatic drain(input string name);
    int n;
    i_pixel_data_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tile_valid"}, o_tile_valid, 1'b0);
    chk({tag, "_frame_done"}, o_frame_done, 1'b0);
    chk({tag, "_tile_row"}, o_tile_row, 1'b0);
    chk({tag, "_tile_col"}, o_tile_col, 2'd0);
    chk({tag, "_tile_data"}, o_tile_data, '0);
    chk({tag, "_pixel_ready"}, o_pixel_ready, 1'b1);
  endtask

  // Consumer-side ready driver.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       i_tile_ready = 1'b0;
      1:       i_tile_ready = 1'b1;
      default: i_tile_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-stability during stalls.
  initial begin
    tile_t          t;
    logic           prev_stall;
    logic [TDW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (o_frame_done) fdone_cnt++;
        if (prev_stall) chk("mon_stall_data_stable", o_tile_data, prev_data);
        if (o_tile_valid && i_tile_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tile: got tile (%0d,%0d) expected none", o_tile_row, o_tile_col);
          end else begin
            t = exp_q.pop_front();
            chk("mon_tile_data", o_tile_data, t.data);
            chk("mon_tile_row", o_tile_row, t.row);
            chk("mon_tile_col", o_tile_col, t.col);
          end
        end
        prev_stall = o_tile_valid && !i_tile_ready;
        prev_data  = o_tile_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_released");

    test_id = 1;
    ready_mode = 1;
    fd0 = fdone_cnt;
    run_frame(1'b0, NB, 1'b0);
    drain("t1_all_tiles_seen");
    chk("t1_done_count", fdone_cnt - fd0, 1);

    test_id = 3;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(1'b0, NB, 1'b0);
    drain("t3_all_tiles_seen");

    test_id = 4;
    ready_mode = 2;
    run_frame(1'b1, NB, 1'b1);
    drain("t4_all_tiles_seen");

    test_id = 5;
    ready_mode = 1;
    run_frame(1'b0, 120, 1'b0);
    i_pixel_data_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("t5_pre_reset_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("t5_in_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("t5_after_reset");
    run_frame(1'b0, NB, 1'b0);
    drain("t5_fresh_frame_tiles");

    test_id = 6;
    ready_mode = 2;
    fd0 = fdone_cnt;
    run_frame(1'b1, NB, 1'b0);
    run_frame(1'b1, NB, 1'b0);
    drain("t6_all_tiles_seen");
    chk("t6_done_count", fdone_cnt - fd0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
